// File: rtl/fmul.sv
// ---------------------------------------------------------------------------
// fmul -- sequential floating-point multiplier, radix-64 fraction format.
//
// Operand/result format (31 bits):
//   [30]    sign
//   [29:24] excess-32 exponent
//   [23:0]  mantissa, four six-bit bytes of a radix-64 fraction
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset_n      asynchronous active-low reset
//   start        one-cycle pulse; begins an operation, samples multiplicand
//   multiplicand rA operand, sampled on the start edge
//   multiplier   memory operand, sampled on the edge after start
//   stop         one-cycle pulse marking out/overflow valid
//   out          product, held until the next completed operation
//   overflow     final exponent outside 0..63
//
// Timing: start sampled at edge E0, multiplier at E1, mantissa product built
// three bits per edge at E2..E9, result registered together with stop at E10.
// ---------------------------------------------------------------------------
module fmul (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [30:0] multiplicand,
    input  logic [30:0] multiplier,
    output logic        stop,
    output logic [30:0] out,
    output logic        overflow
);

    // Control
    logic              run;
    logic [3:0]        count;

    // Datapath state
    logic              sign_a;
    logic [5:0]        exp_a;
    logic [23:0]       mant_a;
    logic              sign_r;
    logic signed [8:0] exp_sum;   // eA + eB - 32, range -32..94
    logic [23:0]       mb;        // multiplier mantissa, consumed 3 bits per step
    logic [47:0]       acc;       // shifting partial-product register

    // Combinational step and finalize terms
    logic [26:0]       pp;
    logic [47:0]       acc_next;
    logic              norm_hi;
    logic [23:0]       mant_n;
    logic              guard;
    logic signed [8:0] exp_n;
    logic [24:0]       mant_rnd;
    logic [23:0]       mant_f;
    logic signed [8:0] exp_f;
    logic [30:0]       res;
    logic              res_ovf;

    // One radix-8 step: the new digit's partial product enters at the top
    // while earlier ones shift down by three. After eight steps the register
    // holds the exact 48-bit product; bits shifted out are always zero.
    // NOTE: every combinational output gets a default first so no latch is
    // inferred on any path.
    always_comb begin
        pp       = {3'b000, mant_a} * {24'd0, mb[2:0]};
        acc_next = {3'b000, acc[47:3]} + {pp, 21'd0};
    end

    // Normalize by at most one byte, round half-up, handle carry-out.
    always_comb begin
        norm_hi  = |acc[47:42];
        mant_n   = norm_hi ? acc[47:24] : acc[41:18];
        guard    = norm_hi ? acc[23]    : acc[17];
        exp_n    = norm_hi ? exp_sum    : exp_sum - 9'sd1;
        mant_rnd = {1'b0, mant_n} + {24'd0, guard};
        mant_f   = mant_rnd[23:0];
        exp_f    = exp_n;
        if (mant_rnd[24]) begin
            // 0xFFFFFF + 1 wraps to one full radix-64 byte: 1/64 at exponent+1
            mant_f = 24'h040000;
            exp_f  = exp_n + 9'sd1;
        end
        res     = {sign_r, exp_f[5:0], mant_f};
        res_ovf = (exp_f > 9'sd63) || (exp_f < 9'sd0);
        // A zero product means one mantissa was zero: signed zero, no overflow
        if (acc == 48'd0) begin
            res     = {sign_r, 30'd0};
            res_ovf = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    // NOTE: the datapath registers are reset along with control so that out
    // and overflow read zero after reset; they are few and flat, not a memory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run      <= 1'b0;
            count    <= 4'd0;
            stop     <= 1'b0;
            sign_a   <= 1'b0;
            exp_a    <= 6'd0;
            mant_a   <= 24'd0;
            sign_r   <= 1'b0;
            exp_sum  <= 9'sd0;
            mb       <= 24'd0;
            acc      <= 48'd0;
            out      <= 31'd0;
            overflow <= 1'b0;
        end else if (start) begin
            // Start wins over everything, also abandoning a running operation
            run    <= 1'b1;
            count  <= 4'd0;
            stop   <= 1'b0;
            sign_a <= multiplicand[30];
            exp_a  <= multiplicand[29:24];
            mant_a <= multiplicand[23:0];
        end else begin
            stop <= 1'b0;
            if (run) begin
                if (count == 4'd9) begin
                    stop     <= 1'b1;
                    run      <= 1'b0;
                    count    <= 4'd0;
                    out      <= res;
                    overflow <= res_ovf;
                end else begin
                    count <= count + 4'd1;
                end

                if (count == 4'd0) begin
                    sign_r  <= sign_a ^ multiplier[30];
                    exp_sum <= $signed({3'b000, exp_a})
                             + $signed({3'b000, multiplier[29:24]}) - 9'sd32;
                    mb      <= multiplier[23:0];
                    acc     <= 48'd0;
                end else if (count <= 4'd8) begin
                    acc <= acc_next;
                    mb  <= {3'b000, mb[23:3]};
                end
            end
        end
    end

endmodule

// File: tb/tb_fmul.sv
// ---------------------------------------------------------------------------
// tb_fmul -- directed self-checking bench for fmul.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// Operand inputs carry random junk outside the edges where they are sampled.
// ---------------------------------------------------------------------------
module tb_fmul;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [30:0] multiplicand;
    logic [30:0] multiplier;
    logic        stop;
    logic [30:0] out;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    fmul dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .stop         (stop),
        .out          (out),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [30:0] junk();
        return 31'($urandom);
    endfunction

    // Called at a falling edge; asserts start immediately so it is sampled on
    // the next rising edge. Expects stop 11 falling edges later (the cycle
    // after the tenth rising edge following start).
    task automatic run_op(input string tag, input logic [30:0] a, input logic [30:0] b,
                          input logic [30:0] exp_out, input logic exp_ovf);
        int lat;
        lat          = 0;
        start        = 1'b1;
        multiplicand = a;
        multiplier   = junk();
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            @(negedge clk);
            if (stop) lat = i;
            start        = 1'b0;
            multiplicand = junk();
            multiplier   = (i == 1) ? b : junk();
        end
        check({tag, "_latency"}, 32'(lat), 32'd11);
        check({tag, "_out"}, {1'b0, out}, {1'b0, exp_out});
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
        @(negedge clk);
        check({tag, "_stop_pulse"}, {31'd0, stop}, 32'd0);
        repeat (2) @(negedge clk);
        check({tag, "_hold"}, {1'b0, out}, {1'b0, exp_out});
    endtask

    initial begin
        int nstops;
        int stop_at;

        reset_n      = 1'b0;
        start        = 1'b0;
        multiplicand = junk();
        multiplier   = junk();
        repeat (3) @(negedge clk);
        check("rst_stop", {31'd0, stop}, 32'd0);
        check("rst_out", {1'b0, out}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        // Start on the very first edge after reset release
        @(negedge clk);
        reset_n = 1'b1;
        run_op("one_x_one", 31'h21040000, 31'h21040000, 31'h21040000, 1'b0);
        @(negedge clk);
        run_op("neg_sign", 31'h61040000, 31'h21040000, 31'h61040000, 1'b0);
        @(negedge clk);
        run_op("round", 31'h20FFFFFF, 31'h20800000, 31'h20800000, 1'b0);
        @(negedge clk);
        run_op("ovf_hi", 31'h3F800000, 31'h3F800000, 31'h1E400000, 1'b1);
        @(negedge clk);
        run_op("zero_mant", 31'h41000000, 31'h21040000, 31'h40000000, 1'b0);
        // P = 2^42-1: shift-normalize, round carries out, exponent restored
        @(negedge clk);
        run_op("rnd_carry", 31'h201FFFFF, 31'h20200001, 31'h20040000, 1'b0);
        // Exponent 1+1-32-1 = -31: underflow, low six bits 33
        @(negedge clk);
        run_op("ovf_lo", 31'h01040000, 31'h01040000, 31'h21040000, 1'b1);
        // Exponent 63+33-32-1 = 63: largest legal value
        @(negedge clk);
        run_op("exp_63", 31'h3F040000, 31'h21040000, 31'h3F040000, 1'b0);

        // Restart: second start 4 cycles after the first; one stop only
        @(negedge clk);
        nstops       = 0;
        stop_at      = 0;
        start        = 1'b1;
        multiplicand = 31'h3F800000;
        multiplier   = junk();
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (stop) begin
                nstops++;
                stop_at = i;
            end
            start        = (i == 4);
            multiplicand = (i == 4) ? 31'h61040000 : junk();
            if (i == 1)      multiplier = 31'h3F800000;
            else if (i == 5) multiplier = 31'h20800000;
            else             multiplier = junk();
            if (i == 15) begin
                check("restart_out", {1'b0, out}, 32'h60800000);
                check("restart_ovf", {31'd0, overflow}, 32'd0);
            end
        end
        check("restart_nstops", 32'(nstops), 32'd1);
        check("restart_stop_at", 32'(stop_at), 32'd15);

        // Reset at count=5 aborts the operation; the previous out is cleared
        @(negedge clk);
        nstops       = 0;
        start        = 1'b1;
        multiplicand = 31'h21040000;
        multiplier   = junk();
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (stop) nstops++;
            start        = 1'b0;
            multiplicand = junk();
            multiplier   = (i == 1) ? 31'h21040000 : junk();
            if (i == 6) reset_n = 1'b0;
            if (i == 8) reset_n = 1'b1;
        end
        check("abort_nstops", 32'(nstops), 32'd0);
        check("abort_out", {1'b0, out}, 32'd0);
        check("abort_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        run_op("after_abort", 31'h61040000, 31'h61040000, 31'h21040000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
